// File: rtl/lstm_input_fetch_ctrl.sv
// rtl/lstm_input_fetch_ctrl.sv - packs input-memory bytes into per-timestep vectors for the LSTM cell
// Optional FETCH_CHECKSUM_EN adds a 16-bit running byte sum output (chksum).
module lstm_input_fetch_ctrl #(
    parameter int VEC_LEN = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int STEP_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [STEP_W-1:0]         num_steps,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [VEC_LEN*DATA_W-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [STEP_W-1:0]         step_idx,
    output logic                      busy,
`ifdef FETCH_CHECKSUM_EN
    output logic [15:0]               chksum,
`endif
    output logic                      done
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [STEP_W-1:0]  num_lat;
    logic               last_byte;
    logic               last_step;

    assign last_byte = (byte_cnt == CNT_W'(VEC_LEN - 1));
    assign last_step = (step_idx == num_lat - STEP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_steps == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (last_byte) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_nxt = last_step ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            out_data <= '0;
            step_idx <= '0;
            byte_cnt <= '0;
            num_lat  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr;
                        num_lat  <= num_steps;
                        step_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    out_data[byte_cnt*DATA_W +: DATA_W] <= mem_data;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
                end
                S_HOLD: begin
                    if (out_ready && !last_step) begin
                        step_idx <= step_idx + STEP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_CHECKSUM_EN
    // Sum survives DONE and IDLE so software can read it until the next command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chksum <= '0;
        end else if (state == S_IDLE && start) begin
            chksum <= '0;
        end else if (state == S_FETCH) begin
            chksum <= chksum + 16'(mem_data);
        end
    end
`endif

endmodule

// File: tb/tb_lstm_input_fetch_ctrl.sv
// tb/tb_lstm_input_fetch_ctrl.sv - directed and randomized bench for lstm_input_fetch_ctrl
module tb_lstm_input_fetch_ctrl;

    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_steps;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [V*8-1:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;
`ifdef FETCH_CHECKSUM_EN
    logic [15:0] chksum;
`endif

    logic [7:0] mem [0:65535];
    int total = 0;
    int bad = 0;

    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    lstm_input_fetch_ctrl #(.VEC_LEN(V), .ADDR_W(16), .DATA_W(8), .STEP_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_steps (num_steps),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_idx  (step_idx),
        .busy      (busy),
`ifdef FETCH_CHECKSUM_EN
        .chksum    (chksum),
`endif
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector k of a command starting at base: V consecutive bytes, lowest address in byte 0.
    function automatic logic [V*8-1:0] model_vec(input logic [15:0] base, input int k);
        logic [V*8-1:0] v;
        logic [15:0] a;
        v = '0;
        for (int j = 0; j < V; j++) begin
            a = 16'(int'(base) + k * V + j);
            v[j*8 +: 8] = mem[a];
        end
        return v;
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] base, input int n);
        logic [15:0] s;
        logic [15:0] a;
        s = '0;
        for (int i = 0; i < n * V; i++) begin
            a = 16'(int'(base) + i);
            s = s + 16'(mem[a]);
        end
        return s;
    endfunction

    // stall < 0 picks a random stall per vector; noise drives junk on start/out_ready/params while busy.
    task automatic run(input logic [15:0] base, input int n, input int stall, input bit noise);
        logic [V*8-1:0] held;
        logic [15:0] exp_addr;
        int s;
        start     = 1'b1;
        base_addr = base;
        num_steps = 16'(n);
        tick();
        start     = 1'b0;
        base_addr = 16'($urandom);
        num_steps = 16'($urandom);
        if (n == 0) begin
            chk("zero_done", {63'd0, done}, 64'd1);
            chk("zero_valid", {63'd0, out_valid}, 64'd0);
            chk("zero_busy", {63'd0, busy}, 64'd1);
        end else begin
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < V; j++) begin
                    exp_addr = 16'(int'(base) + k * V + j);
                    chk("fetch_addr", {48'd0, mem_addr}, {48'd0, exp_addr});
                    chk("fetch_valid", {63'd0, out_valid}, 64'd0);
                    chk("fetch_busy", {63'd0, busy}, 64'd1);
                    if (noise) begin
                        start     = 1'($urandom);
                        out_ready = 1'($urandom);
                    end else begin
                        out_ready = 1'b0;
                    end
                    tick();
                end
                start = 1'b0;
                held = model_vec(base, k);
                exp_addr = 16'(int'(base) + (k + 1) * V);
                s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                out_ready = 1'b0;
                for (int w = 0; w < s; w++) begin
                    chk("stall_valid", {63'd0, out_valid}, 64'd1);
                    chk("stall_data", out_data, held);
                    chk("stall_addr", {48'd0, mem_addr}, {48'd0, exp_addr});
                    tick();
                end
                out_ready = 1'b1;
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", out_data, held);
                chk("hold_step", {48'd0, step_idx}, 64'(k));
                chk("hold_done", {63'd0, done}, 64'd0);
                tick();
                out_ready = 1'b0;
            end
            chk("end_done", {63'd0, done}, 64'd1);
            chk("end_busy", {63'd0, busy}, 64'd1);
            chk("end_valid", {63'd0, out_valid}, 64'd0);
        end
`ifdef FETCH_CHECKSUM_EN
        chk("chksum_done", {48'd0, chksum}, {48'd0, model_sum(base, n)});
`endif
        tick();
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
`ifdef FETCH_CHECKSUM_EN
        chk("chksum_held", {48'd0, chksum}, {48'd0, model_sum(base, n)});
`endif
    endtask

    initial begin
        logic [7:0] pat [0:7];
        pat[0] = 8'h95; pat[1] = 8'haa; pat[2] = 8'h82; pat[3] = 8'hca;
        pat[4] = 8'h6c; pat[5] = 8'h49; pat[6] = 8'hae; pat[7] = 8'h90;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'h80;
            mem[8 + i] = pat[i];
        end
        rst = 1'b1; start = 1'b0; base_addr = '0; num_steps = '0; out_ready = 1'b0;
        #12;
        chk("rst_addr", {48'd0, mem_addr}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_step", {48'd0, step_idx}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick();

        chk("vec_80", model_vec(16'h0000, 0), 64'h8080808080808080);
        chk("vec_pat", model_vec(16'h0000, 1), 64'h90ae496cca82aa95);
        run(16'h0000, 1, 0, 1'b0);
        run(16'h0000, 2, 0, 1'b0);
        run(16'h0000, 2, 5, 1'b0);
        run(16'hFFFC, 1, 0, 1'b0);
        run(16'hFFF9, 2, 1, 1'b1);
        run(16'h0000, 0, 0, 1'b0);

        // Zero-step run with start hammered while busy: must not launch a fetch.
        start = 1'b1; base_addr = 16'h1234; num_steps = 16'd0;
        tick();
        base_addr = 16'h4000; num_steps = 16'd3;
        chk("zs_done", {63'd0, done}, 64'd1);
        tick();
        start = 1'b0;
        chk("zs_idle", {63'd0, busy}, 64'd0);
        chk("zs_novalid", {63'd0, out_valid}, 64'd0);

        // Abort a 4-step run during its third FETCH cycle.
        start = 1'b1; base_addr = 16'(400); num_steps = 16'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_addr", {48'd0, mem_addr}, 64'd0);
        chk("abort_data", out_data, 64'd0);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_step", {48'd0, step_idx}, 64'd0);
        tick();
        chk("abort_nodone", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick();
        chk("abort_still_idle", {63'd0, busy}, 64'd0);
        run(16'(400), 4, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run(16'($urandom), int'($urandom_range(1, 4)), -1, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
